// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider: one quotient bit per cycle, MSB first.
// Accept-to-done is 33 cycles (divide-by-zero: 1); start is ignored while busy in CALC.
module divider (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;

  logic        accept;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] partial;
  logic [33:0] trial;
  logic        fits;
  logic [31:0] rem_nx, quo_nx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    accept  = start && (state_q != CALC);
    dvd_neg = is_signed && dividend[31];
    dvs_neg = is_signed && divisor[31];
    dvd_mag = dvd_neg ? (32'd0 - dividend) : dividend;
    dvs_mag = dvs_neg ? (32'd0 - divisor) : divisor;

    // quo_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
    // A non-negative trial is always below the divisor, so it fits in 32 bits.
    partial = {rem_q, quo_q[31]};
    trial   = {1'b0, partial} - {2'b00, dvs_q};
    fits    = (trial[33:32] == 2'b00);
    rem_nx  = fits ? trial[31:0] : partial[31:0];
    quo_nx  = {quo_q[30:0], fits};

    case (state_q)
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          q_d     = negq_q ? (32'd0 - quo_nx) : quo_nx;
          r_d     = negr_q ? (32'd0 - rem_nx) : rem_nx;
          dz_d    = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (divisor == 32'd0) begin
        state_d = DONE;
        q_d     = 32'hFFFF_FFFF;
        r_d     = dividend;
        dz_d    = 1'b1;
      end else begin
        state_d = CALC;
        cnt_d   = 5'd0;
        rem_d   = 32'd0;
        quo_d   = dvd_mag;
        dvs_d   = dvs_mag;
        negq_d  = dvd_neg ^ dvs_neg;
        negr_d  = dvd_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: arithmetic reference model plus per-cycle output compare.
module tb_divider;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] q, r;
  logic        busy, done, div_zero;

  divider dut (
    .clk(clk), .rstn(rstn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    int          due;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vt [12] = '{
    '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF},
    '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001},
    '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000},
    '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001},
    '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF},
    '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
    '{1'b0, 32'h00000007, 32'hFFFFFFFF, 32'h00000000, 32'h00000007},
    '{1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000},
    '{1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000},
    '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{1'b1, 32'h80000000, 32'h00000002, 32'hC0000000, 32'h00000000},
    '{1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678}
  };

  exp_t        expq [$];
  int          cyc = 0;
  int          last_due = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] hq = 32'd0;
  logic [31:0] hr = 32'd0;
  logic        hdz = 1'b0;

  // cyc == k during the cycle that follows the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: truncating signed division, remainder takes the dividend's sign.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edz);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      eq = 32'hFFFFFFFF; er = a; edz = 1'b1;
    end else if (s) begin
      sa = $signed(a); sb = $signed(b);
      qq = sa / sb;    rr = sa % sb;
      eq = qq[31:0];   er = rr[31:0]; edz = 1'b0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Called mid-cycle; start is high for this cycle only and sampled at its closing edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, output int t);
    exp_t e;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    t = cyc;
    if (rstn && cyc >= last_due) begin
      e.t   = cyc;
      e.due = cyc + ((b == 32'd0) ? 1 : 33);
      model(s, a, b, e.q, e.r, e.dz);
      expq.push_back(e);
      last_due = e.due;
    end
    @(negedge clk);
    #1;
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    expq.delete();
    last_due = 0;
    hq = 32'd0; hr = 32'd0; hdz = 1'b0;
  endtask

  initial begin
    logic e_done, e_busy;
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_done = (expq.size() > 0) && (expq[0].due == cyc);
        e_busy = (expq.size() > 0) && (cyc > expq[0].t);
        if (e_done) begin
          e = expq.pop_front();
          hq = e.q; hr = e.r; hdz = e.dz;
        end
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("q", q, hq);
        chk("r", r, hr);
        chk("div_zero", 32'(div_zero), 32'(hdz));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          t, t2;
    logic [31:0] mq, mr;
    logic        mdz;

    model(1'b0, 32'd100, 32'd7, mq, mr, mdz);
    chk("model_100_7_q", mq, 32'd14);
    chk("model_100_7_r", mr, 32'd2);
    model(1'b1, 32'h12345678, 32'd0, mq, mr, mdz);
    chk("model_div0_q", mq, 32'hFFFFFFFF);
    chk("model_div0_r", mr, 32'h12345678);
    chk("model_div0_dz", 32'(mdz), 32'd1);

    wait_cyc(2);
    chk_en = 1'b1;
    issue(1'b0, 32'd5, 32'd1, t);
    rstn = 1'b1;
    wait_cyc(5);

    issue(1'b0, 32'd100, 32'd7, t);
    chk("busy_T+1", 32'(busy), 32'd1);
    wait_cyc(t + 33);
    chk("done_100_7", 32'(done), 32'd1);
    chk("q_100_7", q, 32'd14);
    chk("r_100_7", r, 32'd2);
    wait_cyc(t + 34);
    chk("busy_T+34", 32'(busy), 32'd0);
    wait_cyc(t + 36);

    for (int i = 0; i < 12; i++) begin
      model(vt[i].s, vt[i].a, vt[i].b, mq, mr, mdz);
      chk($sformatf("model_vec%0d_q", i), mq, vt[i].q);
      chk($sformatf("model_vec%0d_r", i), mr, vt[i].r);
      issue(vt[i].s, vt[i].a, vt[i].b, t);
      wait_cyc(t + ((vt[i].b == 32'd0) ? 3 : 36));
    end

    issue(1'b1, 32'h12345678, 32'd0, t);
    chk("div0_done_T+1", 32'(done), 32'd1);
    issue(1'b1, 32'd9, 32'd3, t2);
    wait_cyc(t2 + 33);
    chk("q_9_3", q, 32'd3);
    chk("dz_9_3", 32'(div_zero), 32'd0);
    wait_cyc(t2 + 36);

    issue(1'b0, 32'd1000, 32'd10, t);
    wait_cyc(t + 10);
    issue(1'b1, 32'd5, 32'd5, t2);
    wait_cyc(t + 33);
    chk("q_ignored_start", q, 32'd100);
    issue(1'b0, 32'd77, 32'd7, t2);
    wait_cyc(t2 + 33);
    chk("q_back_to_back", q, 32'd11);
    wait_cyc(t2 + 36);

    issue(1'b0, 32'd123456, 32'd7, t);
    wait_cyc(t + 15);
    apply_reset();
    @(negedge clk);
    #1;
    chk("q_after_abort", q, 32'd0);
    issue(1'b0, 32'd9, 32'd1, t2);
    rstn = 1'b1;
    issue(1'b0, 32'd50, 32'd5, t);
    wait_cyc(t + 33);
    chk("q_50_5", q, 32'd10);
    chk("r_50_5", r, 32'd0);
    wait_cyc(t + 40);

    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL use the following port list, clock and reset first.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low; sampled on rising clk.
REQ-004 start  input  1  request a new division; sampled only when the block can accept one (see REQ-012).
REQ-005 is_signed  input  1  1 = DIV (two's complement operands); 0 = DIVU (unsigned operands); captured with start.
REQ-006 dividend  input  32  numerator; captured with start.
REQ-007 divisor  input  32  denominator; captured with start.
REQ-008 q  output  32  quotient, the LO value.
REQ-009 r  output  32  remainder, the HI value.
REQ-010 busy  output  1  high while state is CALC or DONE.
REQ-011 done  output  1  single-cycle pulse; q, r and div_zero are valid in this cycle and held afterwards.
REQ-011a div_zero  output  1  the last accepted operation had divisor == 0; valid with done and held afterwards.

Function
REQ-012 State machine SHALL be IDLE, CALC, DONE; start SHALL be accepted in IDLE or DONE and ignored in CALC.
REQ-013 On acceptance at edge T, operands and is_signed SHALL be latched; in signed mode the operand magnitudes SHALL be latched and the two result signs recorded.
REQ-014 With divisor != 0, the block SHALL enter CALC for exactly 32 cycles, performing one restoring radix-2 step per cycle, MSB first; remainder width SHALL be 33 bits.
REQ-015 After the 32nd step the block SHALL enter DONE for one cycle with done=1; accept-to-done latency SHALL be 33 cycles.
REQ-016 Signed results SHALL be corrected in the DONE cycle:
  - q negated when operand signs differ.
  - r negated when the dividend is negative, so r takes the sign of the dividend.
REQ-017 Signed -2^31 / -1 SHALL yield q=32'h80000000 and r=0, with no flag.
REQ-018 With divisor == 0, the block SHALL skip CALC and go straight to DONE at T+1 with q=32'hFFFFFFFF, r=dividend and div_zero=1.
REQ-019 From DONE the block SHALL go to IDLE, or to CALC if start is high (back-to-back). q, r and div_zero SHALL hold until the next done.
REQ-020 q and r SHALL NOT change during CALC; internal working registers are separate from the output registers.
REQ-021 Inputs dividend, divisor and is_signed SHALL have no effect when start is not accepted.

Reset
REQ-022 While rstn=0 at a rising edge, the block SHALL set state=IDLE, q=0, r=0, busy=0, done=0 and div_zero=0.
REQ-023 Reset SHALL override start in the same cycle.
REQ-024 Reset in CALC or DONE SHALL abort the operation with no done pulse; the next start after release SHALL behave as from power-up.

Verification
REQ-025 Unsigned 100 / 7, start at T -> busy=1 from T+1; done=1 at T+33; q=14, r=2; busy=0 at T+34.
REQ-026 Signed 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); unsigned 0xFFFFFFF9 / 2 -> q=0x7FFFFFFC, r=1.
REQ-027 Divide by zero, signed 0x12345678 / 0 -> done at T+1, q=0xFFFFFFFF, r=0x12345678, div_zero=1; a following 9/3 -> q=3, r=0, div_zero=0.
REQ-028 Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0 at T+33.
REQ-029 Start pulsed again at T+10 with other operands -> ignored; the result is that of the first operation at T+33. A start asserted during the DONE cycle -> second done 33 cycles later.
REQ-030 rstn=0 at T+15 of a CALC -> all outputs 0 next cycle, no done pulse; a new 50/5 after release -> q=10, r=0 at its T+33.
